sprite_anim_fetcher: RTL and testbench

- Reader side of the per-sprite palette-index ROMs (19-bit read address in, 5-bit palette index out, one-cycle registered read).
- Plays a multi-frame attack animation stored back-to-back in one ROM.
- Converts the VGA beam position into ROM read addresses and returns an aligned palette index plus an opaque-pixel flag to the colour mapper.
- One instance sits between the VGA controller/character logic and each animation ROM.

---
 rtl/sprite_pkg.sv | 8 +
 rtl/sprite_addr_gen.sv | 48 ++++
 rtl/sprite_anim_fetcher.sv | 118 +++++++++++
 tb/tb_sprite_anim_fetcher.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite ROM fetchers.
package sprite_pkg;
  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} anim_state_t;

  localparam int ROM_ADDR_W = 19;
  localparam int PIX_W      = 5;
  localparam logic [PIX_W-1:0] TRANSPARENT = 5'h00;
endpackage

// File: rtl/sprite_addr_gen.sv
// Beam-to-sprite hit test and registered ROM address for one sprite frame.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W = 14,
  parameter int SPR_H = 28
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [9:0]            draw_x_i,
  input  logic [9:0]            draw_y_i,
  input  logic [9:0]            sprite_x_i,
  input  logic [9:0]            sprite_y_i,
  input  logic [ROM_ADDR_W-1:0] base_i,
  input  logic                  en_i,
  output logic [ROM_ADDR_W-1:0] addr_o,
  output logic                  vld_o
);
  logic [10:0]           dx_p0, dy_p0;
  logic                  inside_p0;
  logic [ROM_ADDR_W-1:0] addr_d, addr_p1_q;
  logic                  vld_p1_q;

  // Stage 0: the extra top bit of dx/dy is the borrow when the beam is left of/above the sprite.
  always_comb begin
    dx_p0     = {1'b0, draw_x_i} - {1'b0, sprite_x_i};
    dy_p0     = {1'b0, draw_y_i} - {1'b0, sprite_y_i};
    inside_p0 = !dx_p0[10] && !dy_p0[10] &&
                (dx_p0 < 11'(SPR_W)) && (dy_p0 < 11'(SPR_H));
    addr_d    = base_i;
    if (inside_p0)
      addr_d = base_i + ROM_ADDR_W'(dy_p0) * ROM_ADDR_W'(SPR_W) + ROM_ADDR_W'(dx_p0);
  end

  // Stage 1
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_p1_q <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      addr_p1_q <= addr_d;
      vld_p1_q  <= inside_p0 && en_i;
    end
  end

  assign addr_o = addr_p1_q;
  assign vld_o  = vld_p1_q;
endmodule

// File: rtl/sprite_anim_fetcher.sv
// Plays a multi-frame sprite animation from one ROM and returns aligned palette indices.
module sprite_anim_fetcher #(
  parameter int SPR_W       = 14,
  parameter int SPR_H       = 28,
  parameter int NUM_FRAMES  = 3,
  parameter int FRAME_TICKS = 6,
  parameter logic [sprite_pkg::PIX_W-1:0] TRANSPARENT = sprite_pkg::TRANSPARENT
) (
  input  logic                              Clk,
  input  logic                              Reset_n,
  input  logic                              vsync_tick,
  input  logic                              attack_start,
  input  logic [9:0]                        DrawX,
  input  logic [9:0]                        DrawY,
  input  logic [9:0]                        SpriteX,
  input  logic [9:0]                        SpriteY,
  output logic [sprite_pkg::ROM_ADDR_W-1:0] read_address,
  input  logic [sprite_pkg::PIX_W-1:0]      rom_data,
  output logic [sprite_pkg::PIX_W-1:0]      pixel_idx,
  output logic                              pixel_on,
  output logic                              busy,
  output logic                              anim_done,
  output logic [3:0]                        frame_idx
);
  import sprite_pkg::*;

  localparam int TICK_W   = 8;
  localparam int FRAME_SZ = SPR_W * SPR_H;
  localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(FRAME_TICKS - 1);
  localparam logic [3:0]        LAST_FRAME = 4'(NUM_FRAMES - 1);

  anim_state_t           state_q;
  logic [3:0]            frame_q;
  logic [ROM_ADDR_W-1:0] base_q;
  logic [TICK_W-1:0]     tick_q;
  logic                  busy_q, done_q;
  logic                  vld_p1;
  logic [PIX_W-1:0]      pix_p2_q;
  logic                  on_p2_q;

  // Frame base advances by a constant step, so no multiply by frame number is needed.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      base_q  <= '0;
      tick_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (attack_start) begin
            state_q <= PLAY;
            busy_q  <= 1'b1;
            frame_q <= '0;
            base_q  <= '0;
            tick_q  <= '0;
          end
        end
        PLAY: begin
          if (vsync_tick) begin
            if (tick_q == LAST_TICK) begin
              tick_q <= '0;
              if (frame_q == LAST_FRAME) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                frame_q <= '0;
                base_q  <= '0;
                done_q  <= 1'b1;
              end else begin
                frame_q <= frame_q + 4'd1;
                base_q  <= base_q + ROM_ADDR_W'(FRAME_SZ);
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sprite_addr_gen #(
    .SPR_W(SPR_W),
    .SPR_H(SPR_H)
  ) u_addr_gen (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .draw_x_i   (DrawX),
    .draw_y_i   (DrawY),
    .sprite_x_i (SpriteX),
    .sprite_y_i (SpriteY),
    .base_i     (base_q),
    .en_i       (busy_q),
    .addr_o     (read_address),
    .vld_o      (vld_p1)
  );

  // Stage 2: ROM data is valid the cycle after read_address.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pix_p2_q <= '0;
      on_p2_q  <= 1'b0;
    end else begin
      pix_p2_q <= rom_data;
      on_p2_q  <= vld_p1 && (rom_data != TRANSPARENT);
    end
  end

  assign pixel_idx = pix_p2_q;
  assign pixel_on  = on_p2_q;
  assign busy      = busy_q;
  assign anim_done = done_q;
  assign frame_idx = frame_q;
endmodule

// File: tb/tb_sprite_anim_fetcher.sv
// Bench for sprite_anim_fetcher: vector table through a scoreboard plus FSM sequences.
module tb_sprite_anim_fetcher;
  logic        Clk = 1'b0;
  logic        Reset_n, vsync_tick, attack_start;
  logic [9:0]  DrawX, DrawY, SpriteX, SpriteY;
  logic [18:0] read_address;
  logic [4:0]  rom_data, pixel_idx;
  logic        pixel_on, busy, anim_done;
  logic [3:0]  frame_idx;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  sprite_anim_fetcher dut (
    .Clk(Clk), .Reset_n(Reset_n), .vsync_tick(vsync_tick), .attack_start(attack_start),
    .DrawX(DrawX), .DrawY(DrawY), .SpriteX(SpriteX), .SpriteY(SpriteY),
    .read_address(read_address), .rom_data(rom_data), .pixel_idx(pixel_idx),
    .pixel_on(pixel_on), .busy(busy), .anim_done(anim_done), .frame_idx(frame_idx)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (anim_done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0]  dx, dy, sx, sy;
    logic [4:0]  rom;
    logic [18:0] ea;
    logic [4:0]  ei;
    logic        eo;
  } vec_t;

  typedef struct {
    int          id;
    logic [18:0] ea;
    logic [4:0]  rom;
    logic [4:0]  ei;
    logic        eo;
  } exp_t;

  vec_t tbl[12];
  exp_t aq[$];
  exp_t pq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_tick();
    vsync_tick = 1'b1;
    clk1();
    vsync_tick = 1'b0;
    clk1();
  endtask

  task automatic pulse_start();
    attack_start = 1'b1;
    clk1();
    attack_start = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    clk1();
    Reset_n = 1'b1;
  endtask

  // ROM model: returns the data of the address emitted on the previous cycle.
  task automatic run_vectors(input int lo, input int hi);
    exp_t e;
    for (int i = lo; i <= hi + 1; i++) begin
      if (i <= hi) begin
        DrawX = tbl[i].dx; DrawY = tbl[i].dy;
        SpriteX = tbl[i].sx; SpriteY = tbl[i].sy;
        aq.push_back('{i, tbl[i].ea, tbl[i].rom, tbl[i].ei, tbl[i].eo});
      end
      rom_data = (pq.size() > 0) ? pq[0].rom : 5'h00;
      clk1();
      if (pq.size() > 0) begin
        e = pq.pop_front();
        check($sformatf("pixel_idx[%0d]", e.id), 32'(pixel_idx), 32'(e.ei));
        check($sformatf("pixel_on[%0d]", e.id), 32'(pixel_on), 32'(e.eo));
      end
      if (aq.size() > 0) begin
        e = aq.pop_front();
        check($sformatf("read_address[%0d]", e.id), 32'(read_address), 32'(e.ea));
        pq.push_back(e);
      end
    end
  endtask

  initial begin
    int exp_frame;
    int d0;
    // idle, base 0
    tbl[0]  = '{10'd105, 10'd53, 10'd100, 10'd50, 5'h07, 19'd47,   5'h07, 1'b0};
    // frame 1, base 392
    tbl[1]  = '{10'd105, 10'd53, 10'd100, 10'd50, 5'h07, 19'd439,  5'h07, 1'b1};
    tbl[2]  = '{10'd105, 10'd53, 10'd100, 10'd50, 5'h00, 19'd439,  5'h00, 1'b0};
    tbl[3]  = '{10'd100, 10'd50, 10'd100, 10'd50, 5'h1F, 19'd392,  5'h1F, 1'b1};
    tbl[4]  = '{10'd99,  10'd53, 10'd100, 10'd50, 5'h07, 19'd392,  5'h07, 1'b0};
    tbl[5]  = '{10'd114, 10'd53, 10'd100, 10'd50, 5'h07, 19'd392,  5'h07, 1'b0};
    tbl[6]  = '{10'd113, 10'd77, 10'd100, 10'd50, 5'h0A, 19'd783,  5'h0A, 1'b1};
    tbl[7]  = '{10'd105, 10'd78, 10'd100, 10'd50, 5'h0A, 19'd392,  5'h0A, 1'b0};
    // frame 2, base 784
    tbl[8]  = '{10'd113, 10'd77, 10'd100, 10'd50, 5'h0C, 19'd1175, 5'h0C, 1'b1};
    tbl[9]  = '{10'd114, 10'd77, 10'd100, 10'd50, 5'h0C, 19'd784,  5'h0C, 1'b0};
    tbl[10] = '{10'd100, 10'd49, 10'd100, 10'd50, 5'h0C, 19'd784,  5'h0C, 1'b0};
    tbl[11] = '{10'd639, 10'd479, 10'd630, 10'd460, 5'h03, 19'd1059, 5'h03, 1'b1};

    // Reset held 3 clocks while start/tick requests arrive, beam inside box.
    Reset_n = 1'b0; attack_start = 1'b1; vsync_tick = 1'b0; rom_data = 5'h07;
    DrawX = 10'd105; DrawY = 10'd53; SpriteX = 10'd100; SpriteY = 10'd50;
    for (int i = 0; i < 3; i++) begin
      vsync_tick = i[0];
      clk1();
    end
    attack_start = 1'b0; vsync_tick = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_pixel_on", 32'(pixel_on), 0);
    check("rst_pixel_idx", 32'(pixel_idx), 0);
    check("rst_read_address", 32'(read_address), 0);
    check("rst_frame_idx", 32'(frame_idx), 0);
    check("rst_anim_done_cnt", 32'(done_cnt), 0);
    Reset_n = 1'b1;
    clk1();
    check("post_rst_busy", 32'(busy), 0);

    // Addressing and boundaries across frames.
    run_vectors(0, 0);
    pulse_start();
    check("start_busy", 32'(busy), 1);
    for (int k = 0; k < 6; k++) pulse_tick();
    check("frame1_idx", 32'(frame_idx), 1);
    run_vectors(1, 7);
    for (int k = 0; k < 6; k++) pulse_tick();
    check("frame2_idx", 32'(frame_idx), 2);
    run_vectors(8, 11);
    d0 = done_cnt;
    for (int k = 0; k < 6; k++) pulse_tick();
    check("addr_run_done_cnt", 32'(done_cnt - d0), 1);
    check("addr_run_busy", 32'(busy), 0);

    // Full play: start coincides with a tick (not counted), redundant start mid-play.
    d0 = done_cnt;
    attack_start = 1'b1; vsync_tick = 1'b1;
    clk1();
    attack_start = 1'b0; vsync_tick = 1'b0;
    check("play_busy0", 32'(busy), 1);
    check("play_frame0", 32'(frame_idx), 0);
    for (int k = 1; k <= 18; k++) begin
      vsync_tick = 1'b1;
      clk1();
      vsync_tick = 1'b0;
      if (k == 18) check("play_done_pulse", 32'(anim_done), 1);
      clk1();
      if (k == 18) check("play_done_width", 32'(anim_done), 0);
      exp_frame = (k >= 18) ? 0 : k / 6;
      check($sformatf("play_frame_t%0d", k), 32'(frame_idx), 32'(exp_frame));
      check($sformatf("play_busy_t%0d", k), 32'(busy), (k < 18) ? 1 : 0);
      if (k == 8) pulse_start();
    end
    check("play_done_cnt", 32'(done_cnt - d0), 1);

    // Reset during frame 1 aborts without anim_done.
    d0 = done_cnt;
    pulse_start();
    for (int k = 0; k < 7; k++) pulse_tick();
    check("abort_frame_before", 32'(frame_idx), 1);
    do_reset();
    check("abort_busy", 32'(busy), 0);
    check("abort_frame", 32'(frame_idx), 0);
    for (int k = 0; k < 20; k++) pulse_tick();
    check("abort_stays_idle", 32'(busy), 0);
    check("abort_no_done", 32'(done_cnt - d0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
